sram_port_ctrl: RTL and testbench

Bus-side controller that sits directly upstream of the single-port 16-bit byte-enabled `altsyncram` instance. It converts the core's access/ack memory bus into the RAM's address/data/wren/byteena port and waits out the RAM read latency. After reset it sweeps the whole array to a known value before any bus traffic is served. It returns data with a single-cycle registered `m_ack`.

---
 rtl/sram_port_ctrl.sv | 115 +++++++++++
 tb/tb_sram_port_ctrl.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_ctrl.sv
// sram_port_ctrl: bus-side controller in front of a single-port, 16-bit,
// byte-enabled synchronous RAM. After reset it optionally sweeps the whole
// array to CLEAR_VALUE, then serves access/ack bus requests and waits out the
// RAM read latency before returning data with a one-cycle registered ack.
//
// state | meaning
// ------+-----------------------------------------------------------------
// CLEAR | post-reset sweep, one clear write per cycle, bus stalled
// IDLE  | waiting for a request (not accepted while m_ack is still shown)
// WACK  | write issued to RAM, acknowledge it
// RWAIT | read issued to RAM, count down the read latency then capture q
module sram_port_ctrl #(
    parameter int          ADDR_WIDTH     = 13,
    parameter int          NUMWORDS       = 8192,
    parameter int          READ_LATENCY   = 1,
    parameter int          CLEAR_ON_RESET = 1,
    parameter logic [15:0] CLEAR_VALUE    = 16'h0000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] m_addr,
    input  logic [15:0]           m_data_in,
    output logic [15:0]           m_data_out,
    input  logic                  m_access,
    input  logic                  m_wr_en,
    input  logic [1:0]            m_bytesel,
    output logic                  m_ack,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [15:0]           ram_data,
    output logic                  ram_wren,
    output logic [1:0]            ram_byteena,
    input  logic [15:0]           ram_q,
    output logic                  init_done
);

    typedef enum logic [1:0] {CLEAR, IDLE, WACK, RWAIT} state_t;

    // Counter is one bit wider than the address so that reaching NUMWORDS
    // (the "sweep finished" point) is representable even when
    // NUMWORDS == 2**ADDR_WIDTH.
    localparam logic [ADDR_WIDTH:0] CLR_END     = (ADDR_WIDTH+1)'(NUMWORDS);
    localparam logic [1:0]          RD_WAIT     = 2'(READ_LATENCY);
    localparam state_t              RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
    localparam logic                RESET_DONE  = (CLEAR_ON_RESET == 0);

    state_t                state;
    logic [ADDR_WIDTH:0]   clr_cnt;
    logic [1:0]            wait_cnt;

    // Main controller: sweep, request acceptance, write ack and read-latency wait.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= RESET_STATE;
            clr_cnt     <= '0;
            wait_cnt    <= '0;
            ram_address <= '0;
            ram_data    <= '0;
            ram_wren    <= 1'b0;
            ram_byteena <= 2'b00;
            m_ack       <= 1'b0;
            m_data_out  <= '0;
            init_done   <= RESET_DONE;
        end else begin
            m_ack <= 1'b0;
            case (state)
                CLEAR: begin
                    if (clr_cnt == CLR_END) begin
                        ram_wren  <= 1'b0;
                        init_done <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        ram_wren    <= 1'b1;
                        ram_byteena <= 2'b11;
                        ram_data    <= CLEAR_VALUE;
                        ram_address <= clr_cnt[ADDR_WIDTH-1:0];
                        clr_cnt     <= clr_cnt + 1'b1;
                    end
                end
                IDLE: begin
                    // m_ack is still high in the cycle right after a completion;
                    // the master's request is stale then and must not restart.
                    if (m_access && !m_ack) begin
                        ram_address <= m_addr;
                        ram_byteena <= m_bytesel;
                        if (m_wr_en) begin
                            ram_wren <= 1'b1;
                            ram_data <= m_data_in;
                            state    <= WACK;
                        end else begin
                            ram_wren <= 1'b0;
                            wait_cnt <= RD_WAIT;
                            state    <= RWAIT;
                        end
                    end
                end
                WACK: begin
                    ram_wren <= 1'b0;
                    m_ack    <= 1'b1;
                    state    <= IDLE;
                end
                RWAIT: begin
                    if (wait_cnt == 2'd0) begin
                        m_data_out <= ram_q;
                        m_ack      <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_port_ctrl.sv
// Testbench for sram_port_ctrl. Three instances share one clock:
//   0: NUMWORDS=16, READ_LATENCY=1, clear sweep of 16'hA5A5
//   1: NUMWORDS=16, READ_LATENCY=2 (registered RAM output), same sweep
//   2: NUMWORDS=16, READ_LATENCY=1, no clear sweep
// Each has its own behavioural RAM and a shadow memory; read expectations are
// queued on a scoreboard when the request is driven and popped on ack.
module tb_sram_port_ctrl;
    localparam int          AW = 13;
    localparam int          NW = 16;
    localparam logic [15:0] CV = 16'hA5A5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n     [3];
    logic [AW-1:0] m_addr      [3];
    logic [15:0]   m_data_in   [3];
    logic [15:0]   m_data_out  [3];
    logic          m_access    [3];
    logic          m_wr_en     [3];
    logic [1:0]    m_bytesel   [3];
    logic          m_ack       [3];
    logic [AW-1:0] ram_address [3];
    logic [15:0]   ram_data    [3];
    logic          ram_wren    [3];
    logic [1:0]    ram_byteena [3];
    logic [15:0]   ram_q       [3];
    logic          init_done   [3];

    sram_port_ctrl #(.ADDR_WIDTH(AW), .NUMWORDS(NW), .READ_LATENCY(1),
                     .CLEAR_ON_RESET(1), .CLEAR_VALUE(CV)) dut_a (
        .clk(clk), .reset_n(reset_n[0]), .m_addr(m_addr[0]), .m_data_in(m_data_in[0]),
        .m_data_out(m_data_out[0]), .m_access(m_access[0]), .m_wr_en(m_wr_en[0]),
        .m_bytesel(m_bytesel[0]), .m_ack(m_ack[0]), .ram_address(ram_address[0]),
        .ram_data(ram_data[0]), .ram_wren(ram_wren[0]), .ram_byteena(ram_byteena[0]),
        .ram_q(ram_q[0]), .init_done(init_done[0]));

    sram_port_ctrl #(.ADDR_WIDTH(AW), .NUMWORDS(NW), .READ_LATENCY(2),
                     .CLEAR_ON_RESET(1), .CLEAR_VALUE(CV)) dut_b (
        .clk(clk), .reset_n(reset_n[1]), .m_addr(m_addr[1]), .m_data_in(m_data_in[1]),
        .m_data_out(m_data_out[1]), .m_access(m_access[1]), .m_wr_en(m_wr_en[1]),
        .m_bytesel(m_bytesel[1]), .m_ack(m_ack[1]), .ram_address(ram_address[1]),
        .ram_data(ram_data[1]), .ram_wren(ram_wren[1]), .ram_byteena(ram_byteena[1]),
        .ram_q(ram_q[1]), .init_done(init_done[1]));

    sram_port_ctrl #(.ADDR_WIDTH(AW), .NUMWORDS(NW), .READ_LATENCY(1),
                     .CLEAR_ON_RESET(0), .CLEAR_VALUE(CV)) dut_c (
        .clk(clk), .reset_n(reset_n[2]), .m_addr(m_addr[2]), .m_data_in(m_data_in[2]),
        .m_data_out(m_data_out[2]), .m_access(m_access[2]), .m_wr_en(m_wr_en[2]),
        .m_bytesel(m_bytesel[2]), .m_ack(m_ack[2]), .ram_address(ram_address[2]),
        .ram_data(ram_data[2]), .ram_wren(ram_wren[2]), .ram_byteena(ram_byteena[2]),
        .ram_q(ram_q[2]), .init_done(init_done[2]));

    // Behavioural RAMs: address always registered; instance 1 also registers q.
    logic [15:0]   mem      [3][0:8191];
    logic [AW-1:0] addr_reg [3];
    logic [15:0]   q_reg    [3];

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (ram_wren[i]) begin
                if (ram_byteena[i][0]) mem[i][ram_address[i]][7:0]  <= ram_data[i][7:0];
                if (ram_byteena[i][1]) mem[i][ram_address[i]][15:8] <= ram_data[i][15:8];
            end
            addr_reg[i] <= ram_address[i];
            q_reg[i]    <= mem[i][addr_reg[i]];
        end
    end

    assign ram_q[0] = mem[0][addr_reg[0]];
    assign ram_q[1] = q_reg[1];
    assign ram_q[2] = mem[2][addr_reg[2]];

    logic [15:0] shadow [3][0:8191];
    logic [15:0] sb_q [$];
    int checks = 0;
    int errors = 0;

    // Drives one request at a negedge and waits for its ack. lat counts
    // edges after the accepting edge E0 until m_ack is seen (-1 = none).
    task automatic do_access(input int inst, input logic wr, input logic [AW-1:0] addr,
                             input logic [15:0] data, input logic [1:0] bs,
                             output int lat, output int wcnt,
                             output logic [15:0] dout, output logic dbl);
        m_addr[inst]    = addr;
        m_data_in[inst] = data;
        m_wr_en[inst]   = wr;
        m_bytesel[inst] = bs;
        m_access[inst]  = 1'b1;
        if (wr) begin
            if (bs[0]) shadow[inst][addr][7:0]  = data[7:0];
            if (bs[1]) shadow[inst][addr][15:8] = data[15:8];
        end else begin
            sb_q.push_back(shadow[inst][addr]);
        end
        lat  = -1;
        wcnt = 0;
        dout = 'x;
        dbl  = 1'b0;
        @(posedge clk);
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (ram_wren[inst]) wcnt++;
            if (m_ack[inst]) begin
                lat  = n;
                dout = m_data_out[inst];
                break;
            end
            @(posedge clk);
        end
        m_access[inst] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        dbl = m_ack[inst];
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            reset_n[i] = 1'b0; m_access[i] = 1'b0; m_wr_en[i] = 1'b0;
            m_addr[i] = '0; m_data_in[i] = '0; m_bytesel[i] = 2'b00;
        end
        for (int i = 0; i < 2; i++)
            for (int a = 0; a < NW; a++) shadow[i][a] = CV;
        #12;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({m_ack[i], ram_wren[i], ram_byteena[i], ram_address[i], ram_data[i], m_data_out[i]} !== '0) begin
                errors++;
                $display("FAIL reset_outputs inst=%0d ack=%b wren=%b be=%b addr=%0h data=%0h dout=%0h, all must be 0",
                         i, m_ack[i], ram_wren[i], ram_byteena[i], ram_address[i], ram_data[i], m_data_out[i]);
            end
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (init_done[i] !== 1'b0) begin
                errors++; $display("FAIL reset_init_done inst=%0d got %b exp 0", i, init_done[i]);
            end
        end
    endtask

    task automatic test_clear();
        logic [15:0] exp;
        int ack_edge = -1;
        @(negedge clk);
        m_addr[0] = AW'(7); m_wr_en[0] = 1'b0; m_bytesel[0] = 2'b11; m_access[0] = 1'b1;
        sb_q.push_back(shadow[0][7]);
        reset_n[0] = 1'b1;
        reset_n[1] = 1'b1;
        for (int e = 1; e <= 17; e++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (m_ack[0] !== 1'b0) begin
                errors++; $display("FAIL clear_no_ack edge=%0d got %b exp 0", e, m_ack[0]);
            end
            if (e <= 16) begin
                checks++;
                if ({ram_wren[0], ram_byteena[0], ram_address[0], ram_data[0], init_done[0]} !==
                    {1'b1, 2'b11, AW'(e-1), CV, 1'b0}) begin
                    errors++;
                    $display("FAIL clear_write edge=%0d wren=%b be=%b addr=%0d data=%0h done=%b exp wren=1 be=11 addr=%0d data=%0h done=0",
                             e, ram_wren[0], ram_byteena[0], ram_address[0], ram_data[0], init_done[0], e-1, CV);
                end
            end else begin
                checks++;
                if ({ram_wren[0], init_done[0]} !== 2'b01) begin
                    errors++; $display("FAIL clear_end wren=%b done=%b exp wren=0 done=1", ram_wren[0], init_done[0]);
                end
            end
        end
        for (int e = 18; e <= 30; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (m_ack[0]) begin ack_edge = e; break; end
        end
        checks++;
        if (ack_edge != 20) begin
            errors++; $display("FAIL clear_read_ack_edge got %0d exp 20", ack_edge);
        end
        exp = sb_q.pop_front();
        checks++;
        if (m_data_out[0] !== exp || exp !== CV) begin
            errors++; $display("FAIL clear_read_data got %0h exp %0h", m_data_out[0], exp);
        end
        m_access[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (init_done[1] !== 1'b1) begin
            errors++; $display("FAIL clear_done_lat2 got %b exp 1", init_done[1]);
        end
    endtask

    task automatic test_write_read();
        int lat, wcnt; logic [15:0] dout, exp; logic dbl;
        do_access(0, 1'b1, AW'('h0ABC), 16'h1234, 2'b11, lat, wcnt, dout, dbl);
        checks++;
        if (lat != 1 || wcnt != 1 || dbl !== 1'b0) begin
            errors++; $display("FAIL wr_timing lat=%0d wren_cycles=%0d dbl=%b exp 1 1 0", lat, wcnt, dbl);
        end
        do_access(0, 1'b0, AW'('h0ABC), 16'h0000, 2'b11, lat, wcnt, dout, dbl);
        exp = sb_q.pop_front();
        checks++;
        if (lat != 2 || wcnt != 0 || dbl !== 1'b0) begin
            errors++; $display("FAIL rd_timing lat=%0d wren_cycles=%0d dbl=%b exp 2 0 0", lat, wcnt, dbl);
        end
        checks++;
        if (dout !== exp || dout !== 16'h1234) begin
            errors++; $display("FAIL rd_data got %0h exp %0h", dout, exp);
        end
    endtask

    task automatic test_byte_lanes();
        logic        t_wr [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [15:0] t_d  [6] = '{16'hFF00, 16'h0, 16'h0077, 16'h0, 16'hBEEF, 16'h0};
        logic [1:0]  t_bs [6] = '{2'b10, 2'b11, 2'b01, 2'b11, 2'b00, 2'b11};
        logic [15:0] t_ex [6] = '{16'h0, 16'hFF34, 16'h0, 16'hFF77, 16'h0, 16'hFF77};
        int lat, wcnt; logic [15:0] dout, exp; logic dbl;
        for (int k = 0; k < 6; k++) begin
            do_access(0, t_wr[k], AW'('h0ABC), t_d[k], t_bs[k], lat, wcnt, dout, dbl);
            checks++;
            if (lat != (t_wr[k] ? 1 : 2) || dbl !== 1'b0) begin
                errors++; $display("FAIL lane_ack step=%0d lat=%0d dbl=%b exp lat %0d dbl 0", k, lat, dbl, t_wr[k] ? 1 : 2);
            end
            if (!t_wr[k]) begin
                exp = sb_q.pop_front();
                checks++;
                if (dout !== exp || dout !== t_ex[k]) begin
                    errors++; $display("FAIL lane_data step=%0d got %0h exp %0h", k, dout, t_ex[k]);
                end
            end
        end
    endtask

    task automatic test_latency2();
        int lat, wcnt, last, nack; logic [15:0] dout, exp; logic dbl, prev;
        logic [AW-1:0] ba [3];
        do_access(1, 1'b1, AW'(5), 16'h1357, 2'b11, lat, wcnt, dout, dbl);
        checks++;
        if (lat != 1 || wcnt != 1) begin
            errors++; $display("FAIL l2_wr lat=%0d wren_cycles=%0d exp 1 1", lat, wcnt);
        end
        do_access(1, 1'b0, AW'(5), 16'h0, 2'b11, lat, wcnt, dout, dbl);
        exp = sb_q.pop_front();
        checks++;
        if (lat != 3 || dbl !== 1'b0 || dout !== exp || dout !== 16'h1357) begin
            errors++; $display("FAIL l2_rd lat=%0d dbl=%b data=%0h exp lat 3 dbl 0 data %0h", lat, dbl, dout, exp);
        end
        ba[0] = AW'(0); ba[1] = AW'(5); ba[2] = AW'(1);
        last = -1; nack = 0; prev = 1'b0;
        m_addr[1] = ba[0]; m_wr_en[1] = 1'b0; m_bytesel[1] = 2'b11; m_access[1] = 1'b1;
        sb_q.push_back(shadow[1][ba[0]]);
        for (int c = 1; c <= 60 && nack < 3; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (m_ack[1]) begin
                checks++;
                if (prev) begin
                    errors++; $display("FAIL b2b_double_ack cycle=%0d got consecutive ack exp single", c);
                end
                if (last >= 0) begin
                    checks++;
                    if (c - last < 4) begin
                        errors++; $display("FAIL b2b_spacing got %0d cycles exp at least 4", c - last);
                    end
                end
                last = c;
                nack++;
                exp = (sb_q.size() > 0) ? sb_q.pop_front() : 16'hxxxx;
                checks++;
                if (m_data_out[1] !== exp) begin
                    errors++; $display("FAIL b2b_data ack=%0d got %0h exp %0h", nack, m_data_out[1], exp);
                end
                if (nack < 3) begin
                    m_addr[1] = ba[nack];
                    sb_q.push_back(shadow[1][ba[nack]]);
                end else begin
                    m_access[1] = 1'b0;
                end
            end
            prev = m_ack[1];
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (nack != 3 || m_ack[1] !== 1'b0) begin
            errors++; $display("FAIL b2b_count got %0d acks trailing=%b exp 3 acks trailing 0", nack, m_ack[1]);
        end
    endtask

    task automatic test_reset_mid();
        logic ack_seen = 1'b0;
        int hit = 0;
        m_addr[0] = AW'(7); m_wr_en[0] = 1'b0; m_access[0] = 1'b1;
        @(posedge clk);            // E0: accepted
        @(posedge clk);            // E1: in RWAIT
        #2 reset_n[0] = 1'b0;
        #1;
        checks++;
        if ({m_ack[0], ram_wren[0], ram_byteena[0], ram_address[0], ram_data[0], m_data_out[0], init_done[0]} !== '0) begin
            errors++; $display("FAIL rst_rwait addr=%0h be=%b dout=%0h ack=%b done=%b exp all 0",
                               ram_address[0], ram_byteena[0], m_data_out[0], m_ack[0], init_done[0]);
        end
        m_access[0] = 1'b0;
        repeat (2) begin @(negedge clk); ack_seen |= m_ack[0]; end
        reset_n[0] = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            @(posedge clk);
            @(negedge clk);
            ack_seen |= m_ack[0];
            if (e == 1) begin
                checks++;
                if ({ram_wren[0], ram_address[0]} !== {1'b1, AW'(0)}) begin
                    errors++; $display("FAIL rst_rwait_restart wren=%b addr=%0d exp 1 0", ram_wren[0], ram_address[0]);
                end
            end
            if (ram_wren[0] && ram_address[0] == AW'(5)) begin hit = e; break; end
        end
        #1 reset_n[0] = 1'b0;
        #1;
        checks++;
        if (hit != 6 || {m_ack[0], ram_wren[0], ram_address[0], ram_data[0], init_done[0]} !== '0) begin
            errors++; $display("FAIL rst_sweep hit_edge=%0d wren=%b addr=%0d data=%0h exp edge 6 and all 0",
                               hit, ram_wren[0], ram_address[0], ram_data[0]);
        end
        @(negedge clk);
        reset_n[0] = 1'b1;
        for (int e = 1; e <= 2; e++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if ({ram_wren[0], ram_address[0]} !== {1'b1, AW'(e-1)}) begin
                errors++; $display("FAIL rst_sweep_restart edge=%0d wren=%b addr=%0d exp 1 %0d", e, ram_wren[0], ram_address[0], e-1);
            end
        end
        for (int e = 0; e < 40 && !init_done[0]; e++) begin
            @(negedge clk);
            ack_seen |= m_ack[0];
        end
        checks++;
        if (ack_seen !== 1'b0 || init_done[0] !== 1'b1) begin
            errors++; $display("FAIL rst_no_ack ack_seen=%b done=%b exp 0 1", ack_seen, init_done[0]);
        end
    endtask

    task automatic test_no_clear();
        int lat, wcnt; logic [15:0] dout, exp; logic dbl;
        @(negedge clk);
        reset_n[2] = 1'b1;
        do_access(2, 1'b1, AW'(3), 16'hC0DE, 2'b11, lat, wcnt, dout, dbl);
        checks++;
        if (lat != 1 || wcnt != 1 || init_done[2] !== 1'b1) begin
            errors++; $display("FAIL noclr_first_wr lat=%0d wren_cycles=%0d done=%b exp 1 1 1", lat, wcnt, init_done[2]);
        end
        do_access(2, 1'b0, AW'(3), 16'h0, 2'b11, lat, wcnt, dout, dbl);
        exp = sb_q.pop_front();
        checks++;
        if (lat != 2 || dout !== exp || dout !== 16'hC0DE) begin
            errors++; $display("FAIL noclr_rd lat=%0d data=%0h exp 2 %0h", lat, dout, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_clear();
        test_write_read();
        test_byte_lanes();
        test_latency2();
        test_no_clear();
        test_reset_mid();
        checks++;
        if (sb_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_leftover got %0d entries exp 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
